dvp_rgb565_receiver: RTL and testbench

- Captures an 8-bit parallel DVP camera bus (din/href/vsync, sampled on pclk) and turns it into an AXI4-Stream-style byte stream with end-of-line marking.
- Pairs consecutive bytes into 16-bit RGB565 pixels, with start-of-frame and end-of-line flags.
- Sits between the sensor pins and the video DMA/line buffer.
- Has no backpressure: the sensor cannot be stalled, so the downstream sink must accept every beat.

---
 rtl/dvp_rgb565_receiver_if.sv | 10 +
 rtl/dvp_rgb565_receiver.sv | 159 +++++++++++++++
 tb/tb_dvp_rgb565_receiver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_rgb565_receiver_if.sv
// Pixel stream leaving the DVP receiver: AXI4-Stream style, no backpressure.
interface dvp_rgb565_receiver_if;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;

    modport master (output m_tdata, m_tvalid, m_tlast, m_tuser);
    modport slave  (input  m_tdata, m_tvalid, m_tlast, m_tuser);
endinterface

// File: rtl/dvp_rgb565_receiver.sv
// DVP camera bus capture: registers din/href/vsync, builds a byte stream with
// a last-byte flag, pairs bytes into RGB565 pixels and tracks line/frame sizes.
module dvp_rgb565_receiver #(
    parameter int BYTE_SWAP         = 0,
    parameter int VSYNC_ACTIVE_HIGH = 1,
    parameter int CNT_W             = 12
) (
    input  logic                    pclk,
    input  logic                    aresetn,
    input  logic [7:0]              din,
    input  logic                    href,
    input  logic                    vsync,
    dvp_rgb565_receiver_if.master   m,
    output logic                    odd_line,
    output logic [CNT_W-1:0]        line_pixels,
    output logic [CNT_W-1:0]        frame_lines
);

    typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

    // stage A / B registers
    logic [7:0]       din_a_q, din_b_q;
    logic             href_a_q, vs_a_q, bvalid_q, vs_act_b_q;
    // stage C state
    phase_t           phase_q, phase_d;
    logic [7:0]       hold_q, hold_d;
    logic             sof_q, sof_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    // registered outputs
    logic [15:0]      tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic             odd_q, odd_d;
    logic [CNT_W-1:0] line_pixels_q, line_pixels_d, frame_lines_q, frame_lines_d;

    logic             vs_act, blast;
    logic [CNT_W-1:0] pix_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign vs_act  = (VSYNC_ACTIVE_HIGH != 0) ? vs_a_q : ~vs_a_q;
    // the byte in stage B is the last of its line when the following sample has href low
    assign blast   = bvalid_q & ~href_a_q;
    assign pix_inc = sat_inc(pix_cnt_q);

    // input capture and byte-stream stages
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            din_a_q    <= '0;
            href_a_q   <= 1'b0;
            vs_a_q     <= 1'b0;
            din_b_q    <= '0;
            bvalid_q   <= 1'b0;
            vs_act_b_q <= 1'b0;
        end else begin
            din_a_q    <= din;
            href_a_q   <= href;
            vs_a_q     <= vsync;
            din_b_q    <= din_a_q;
            bvalid_q   <= href_a_q & ~vs_act;
            vs_act_b_q <= vs_act;
        end
    end

    // pairing state, counters and output registers
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q       <= PH_FIRST;
            hold_q        <= '0;
            sof_q         <= 1'b1;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            odd_q         <= 1'b0;
            line_pixels_q <= '0;
            frame_lines_q <= '0;
        end else begin
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            sof_q         <= sof_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            odd_q         <= odd_d;
            line_pixels_q <= line_pixels_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    // byte pairing, frame sync handling and line/frame counting
    always_comb begin
        phase_d       = phase_q;
        hold_d        = hold_q;
        sof_d         = sof_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        tdata_d       = tdata_q;
        tvalid_d      = 1'b0;
        tlast_d       = 1'b0;
        tuser_d       = 1'b0;
        odd_d         = 1'b0;
        line_pixels_d = line_pixels_q;
        frame_lines_d = frame_lines_q;

        if (vs_act) begin
            // blanking also drops a byte already in stage B, so a cut line never emits tlast;
            // the partial line's pixel count is discarded with it
            sof_d     = 1'b1;
            phase_d   = PH_FIRST;
            hold_d    = '0;
            pix_cnt_d = '0;
            if (!vs_act_b_q) begin
                if (line_cnt_q != '0) begin
                    frame_lines_d = line_cnt_q;
                end
                line_cnt_d = '0;
            end
        end else if (bvalid_q) begin
            if (phase_q == PH_FIRST && !blast) begin
                hold_d  = din_b_q;
                phase_d = PH_SECOND;
            end else begin
                tvalid_d  = 1'b1;
                tlast_d   = blast;
                tuser_d   = sof_q;
                sof_d     = 1'b0;
                odd_d     = (phase_q == PH_FIRST);
                phase_d   = PH_FIRST;
                pix_cnt_d = pix_inc;
                if (phase_q == PH_SECOND) begin
                    tdata_d = (BYTE_SWAP != 0) ? {din_b_q, hold_q} : {hold_q, din_b_q};
                end else begin
                    tdata_d = (BYTE_SWAP != 0) ? {8'h00, din_b_q} : {din_b_q, 8'h00};
                end
                if (blast) begin
                    line_pixels_d = pix_inc;
                    pix_cnt_d     = '0;
                    line_cnt_d    = sat_inc(line_cnt_q);
                end
            end
        end
    end

    assign m.m_tdata   = tdata_q;
    assign m.m_tvalid  = tvalid_q;
    assign m.m_tlast   = tlast_q;
    assign m.m_tuser   = tuser_q;
    assign odd_line    = odd_q;
    assign line_pixels = line_pixels_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_dvp_rgb565_receiver.sv
// Bench for dvp_rgb565_receiver: two instances (normal and byte-swapped) share
// one DVP stimulus; a sample-history model is compared every cycle, and
// directed scenarios are pinned with literal pixel values.
module tb_dvp_rgb565_receiver;
    localparam int CNT_W = 12;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       pclk    = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] din     = '0;
    logic       href    = 1'b0;
    logic       vsync   = 1'b0;

    dvp_rgb565_receiver_if m0 ();
    dvp_rgb565_receiver_if m1 ();
    logic             odd0, odd1;
    logic [CNT_W-1:0] lp0, lp1, fl0, fl1;

    dvp_rgb565_receiver #(.BYTE_SWAP(0), .VSYNC_ACTIVE_HIGH(1), .CNT_W(CNT_W)) dut0 (
        .pclk(pclk), .aresetn(aresetn), .din(din), .href(href), .vsync(vsync),
        .m(m0), .odd_line(odd0), .line_pixels(lp0), .frame_lines(fl0));

    dvp_rgb565_receiver #(.BYTE_SWAP(1), .VSYNC_ACTIVE_HIGH(1), .CNT_W(CNT_W)) dut1 (
        .pclk(pclk), .aresetn(aresetn), .din(din), .href(href), .vsync(vsync),
        .m(m1), .odd_line(odd1), .line_pixels(lp1), .frame_lines(fl1));

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works from the raw pin samples: the byte sampled two edges ago is judged
    // against the sample that followed it (its line end and blanking state).
    typedef struct packed {
        logic       h;
        logic       v;
        logic [7:0] d;
    } smp_t;

    smp_t        p1 = '0, p2 = '0;
    int          ph = 0;
    logic [7:0]  hold = '0;
    bit          sof = 1'b1;
    int          pix = 0, lines = 0;
    logic [15:0] e_data = '0;
    bit          e_valid = 0, e_last = 0, e_user = 0, e_odd = 0;
    int          e_lp = 0, e_fl = 0;

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    always @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            p1 = '0; p2 = '0; ph = 0; hold = '0; sof = 1'b1; pix = 0; lines = 0;
            e_data = '0; e_valid = 0; e_last = 0; e_user = 0; e_odd = 0; e_lp = 0; e_fl = 0;
        end else begin
            e_valid = 0; e_last = 0; e_user = 0; e_odd = 0;
            if (p1.v) begin
                sof = 1'b1; ph = 0; pix = 0;
                if (!p2.v) begin
                    if (lines != 0) e_fl = lines;
                    lines = 0;
                end
            end else if (p2.h && !p2.v) begin
                if (ph == 0 && p1.h) begin
                    hold = p2.d;
                    ph   = 1;
                end else begin
                    e_data  = (ph == 1) ? {hold, p2.d} : {p2.d, 8'h00};
                    e_valid = 1;
                    e_last  = !p1.h;
                    e_odd   = (ph == 0);
                    e_user  = sof;
                    sof     = 1'b0;
                    pix     = sat(pix);
                    if (!p1.h) begin
                        e_lp  = pix;
                        pix   = 0;
                        lines = sat(lines);
                    end
                    ph = 0;
                end
            end
            p2 = p1;
            p1 = '{h: href, v: vsync, d: din};
        end
    end

    // ---------------- per-cycle compare and beat capture ----------------
    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        last;
        logic        user;
        logic        odd;
    } beat_t;
    beat_t bq[$];

    always @(negedge pclk) begin
        if (aresetn) begin
            check("flags0", {m0.m_tvalid, m0.m_tlast, m0.m_tuser, odd0},
                            {e_valid, e_last, e_user, e_odd});
            check("flags1", {m1.m_tvalid, m1.m_tlast, m1.m_tuser, odd1},
                            {e_valid, e_last, e_user, e_odd});
            check("tdata0", m0.m_tdata, e_data);
            check("tdata1", m1.m_tdata, {e_data[7:0], e_data[15:8]});
            check("line_pixels", {lp1, lp0}, {e_lp[CNT_W-1:0], e_lp[CNT_W-1:0]});
            check("frame_lines", {fl1, fl0}, {e_fl[CNT_W-1:0], e_fl[CNT_W-1:0]});
            if (m0.m_tvalid)
                bq.push_back('{d0: m0.m_tdata, d1: m1.m_tdata, last: m0.m_tlast,
                               user: m0.m_tuser, odd: odd0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic h, input logic v, input logic [7:0] d);
        @(negedge pclk);
        href = h; vsync = v; din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse(input int n);
        repeat (n) cyc(1'b0, 1'b1, 8'h00);
        idle(3);
    endtask

    task automatic send_line(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, start + 8'(i));
    endtask

    task automatic expect_beat(input int idx, input logic [15:0] d0, input logic [15:0] d1,
                               input logic last, input logic user, input logic odd);
        if (idx >= bq.size()) begin
            tests++;
            fails++;
            $display("FAIL beat%0d: missing, only %0d beats captured", idx, bq.size());
        end else begin
            check($sformatf("beat%0d_data", idx), {bq[idx].d0, bq[idx].d1}, {d0, d1});
            check($sformatf("beat%0d_flags", idx), {bq[idx].last, bq[idx].user, bq[idx].odd},
                  {last, user, odd});
        end
    endtask

    logic [15:0] ramp [5] = '{16'h1011, 16'h1213, 16'h1415, 16'h1617, 16'h1819};

    initial begin
        // reset state
        repeat (3) @(negedge pclk);
        #1;
        check("rst_out", {m0.m_tvalid, m0.m_tlast, m0.m_tuser, odd0, m0.m_tdata}, '0);
        check("rst_cnt", {lp0, fl0}, '0);
        @(negedge pclk);
        aresetn = 1'b1;

        // first line after a frame sync: ramp 0x10..0x19
        vs_pulse(10);
        bq.delete();
        send_line(8'h10, 10);
        idle(5);
        check("ramp_count", bq.size(), 5);
        for (int i = 0; i < 5; i++)
            expect_beat(i, ramp[i], {ramp[i][7:0], ramp[i][15:8]}, i == 4, i == 0, 1'b0);
        check("ramp_lp", lp0, 5);
        vs_pulse(10);
        check("frame1_fl", fl0, 1);

        // two lines separated by a single-cycle href gap
        bq.delete();
        send_line(8'h20, 10);
        idle(1);
        send_line(8'h40, 10);
        idle(5);
        check("two_count", bq.size(), 10);
        expect_beat(0, 16'h2021, 16'h2120, 1'b0, 1'b1, 1'b0);
        expect_beat(4, 16'h2829, 16'h2928, 1'b1, 1'b0, 1'b0);
        expect_beat(5, 16'h4041, 16'h4140, 1'b0, 1'b0, 1'b0);
        expect_beat(9, 16'h4849, 16'h4948, 1'b1, 1'b0, 1'b0);
        vs_pulse(10);
        check("frame2_fl", fl0, 2);

        // byte order: 0xAB then 0xCD
        bq.delete();
        send_line(8'hAB, 1);
        cyc(1'b1, 1'b0, 8'hCD);
        idle(5);
        check("swap_count", bq.size(), 1);
        expect_beat(0, 16'hABCD, 16'hCDAB, 1'b1, 1'b1, 1'b0);

        // odd byte count line
        bq.delete();
        send_line(8'h01, 5);
        idle(5);
        check("odd_count", bq.size(), 3);
        expect_beat(0, 16'h0102, 16'h0201, 1'b0, 1'b0, 1'b0);
        expect_beat(1, 16'h0304, 16'h0403, 1'b0, 1'b0, 1'b0);
        expect_beat(2, 16'h0500, 16'h0005, 1'b1, 1'b0, 1'b1);
        check("odd_lp", lp0, 3);

        // vsync cuts a line after 3 bytes
        bq.delete();
        send_line(8'h30, 3);
        vs_pulse(5);
        send_line(8'h50, 4);
        idle(5);
        check("cut_count", bq.size(), 3);
        expect_beat(0, 16'h3031, 16'h3130, 1'b0, 1'b0, 1'b0);
        expect_beat(1, 16'h5051, 16'h5150, 1'b0, 1'b1, 1'b0);
        expect_beat(2, 16'h5253, 16'h5352, 1'b1, 1'b0, 1'b0);

        // asynchronous reset in the middle of a line
        bq.delete();
        send_line(8'h60, 4);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_out", {m0.m_tvalid, m0.m_tlast, m0.m_tuser, odd0, m0.m_tdata,
                             m1.m_tvalid, m1.m_tdata}, '0);
        check("midrst_cnt", {lp0, fl0, lp1, fl1}, '0);
        href = 1'b0;
        repeat (3) @(negedge pclk);
        aresetn = 1'b1;
        idle(3);
        send_line(8'h70, 4);
        idle(5);
        check("rst_count", bq.size(), 2);
        expect_beat(0, 16'h7071, 16'h7170, 1'b0, 1'b1, 1'b0);
        expect_beat(1, 16'h7273, 16'h7372, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
